result_collector: RTL and testbench

Packs a stream of signed accumulator results from the systolic array edge into one wide word: one element per accepted strobe, first element in the most-significant slot. It is the drain-side counterpart of the array's data feeders, which unpack the same word layout and shift it out MSB slot first. A one-word holding register with a valid/ready handshake decouples collection from the downstream consumer. Backpressure stalls the array side only when both the collecting word and the holding register are full.

---
 rtl/result_collector.sv | 172 +++++++++++++++++
 tb/tb_result_collector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector: packs a stream of signed accumulator results into one wide
// word (first element in the most-significant slot), with a one-word holding
// register and a valid/ready handshake on the output side.
// Optional feature macro: COLLECTOR_SAT_EN (signed saturation instead of wrap).
module result_collector #(
  parameter int acc_width  = 16,
  parameter int elem_width = 8,
  parameter int num_elems  = 7
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [acc_width-1:0]                in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                flush,
  output logic [elem_width*num_elems-1:0]     out_data,
  output logic [$clog2(num_elems+1)-1:0]      out_count,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                overrun,
  output logic                                sat_seen
);

  localparam int W   = elem_width * num_elems;
  localparam int CW  = $clog2(num_elems + 1);
  localparam int SHW = $clog2(W + 1);

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    hold_data_q, hold_data_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            hold_vld_q, hold_vld_d;
  logic            overrun_q, overrun_d;
  logic            sat_q, sat_d;

  logic [elem_width-1:0] elem;
  logic                  clamp;
  logic                  accept, hold_free, complete, do_flush, emit, load;
  logic [W-1:0]          acc_after, word, load_data;
  logic [CW-1:0]         cnt_after, load_cnt;
  logic [SHW-1:0]        shamt;

`ifdef COLLECTOR_SAT_EN
  localparam logic signed [acc_width-1:0] SAT_MAX =
    {{(acc_width-elem_width+1){1'b0}}, {(elem_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] SAT_MIN =
    {{(acc_width-elem_width+1){1'b1}}, {(elem_width-1){1'b0}}};

  // Narrow by clamping to the signed element range
  always_comb begin
    elem  = in_data[elem_width-1:0];
    clamp = 1'b0;
    if ($signed(in_data) > SAT_MAX) begin
      elem  = SAT_MAX[elem_width-1:0];
      clamp = 1'b1;
    end else if ($signed(in_data) < SAT_MIN) begin
      elem  = SAT_MIN[elem_width-1:0];
      clamp = 1'b1;
    end
  end
`else
  // Upper sample bits are discarded in wrap mode
  logic unused_in_hi;
  assign unused_in_hi = ^in_data[acc_width-1:elem_width];
  assign elem  = in_data[elem_width-1:0];
  assign clamp = 1'b0;
`endif

  // Collect/stall control, word assembly and holding-register update
  always_comb begin
    accept    = in_valid && (state_q == COLLECT);
    hold_free = !hold_vld_q || out_ready;
    acc_after = accept ? {acc_q[W-elem_width-1:0], elem} : acc_q;
    cnt_after = cnt_q + CW'(accept);
    complete  = accept && (cnt_q == CW'(num_elems - 1));
    // A flush on the completing edge is redundant: the word is already full.
    do_flush  = flush && (state_q == COLLECT) && !complete && (cnt_after != '0);
    emit      = complete || do_flush;
    // Left-justify partial words; a full word has a zero shift.
    shamt     = SHW'(elem_width * (num_elems - int'(cnt_after)));
    word      = acc_after << shamt;

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = acc_q;
    load_cnt  = cnt_q;

    case (state_q)
      COLLECT: begin
        acc_d = acc_after;
        cnt_d = cnt_after;
        if (emit) begin
          if (hold_free) begin
            load      = 1'b1;
            load_data = word;
            load_cnt  = cnt_after;
            acc_d     = '0;
            cnt_d     = '0;
          end else begin
            // Park the finished (justified) word until the hold drains.
            state_d = STALL;
            acc_d   = word;
            cnt_d   = cnt_after;
          end
        end
      end
      STALL: begin
        if (hold_free) begin
          load    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    hold_vld_d  = hold_vld_q;
    if (load) begin
      hold_data_d = load_data;
      hold_cnt_d  = load_cnt;
      hold_vld_d  = 1'b1;
    end else if (hold_vld_q && out_ready) begin
      hold_vld_d = 1'b0;
    end

    overrun_d = overrun_q | (in_valid && (state_q != COLLECT));
    sat_d     = sat_q | (accept && clamp);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      hold_vld_q  <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_vld_q  <= hold_vld_d;
      overrun_q   <= overrun_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_data  = hold_data_q;
  assign out_count = hold_cnt_q;
  assign out_valid = hold_vld_q;
  assign overrun   = overrun_q;
`ifdef COLLECTOR_SAT_EN
  assign sat_seen  = sat_q;
`else
  assign sat_seen  = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: scoreboard of expected words,
// popped whenever the DUT hands a word to the consumer.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [55:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;
  logic        sat_seen;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [55:0] data;
    logic [2:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] part[$];
  exp_t       mon_e;

  result_collector dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .sat_seen(sat_seen)
  );

  always #5 clk = ~clk;

  // Reference narrowing of a sample to one element
  function automatic logic [7:0] narrow(input int v);
`ifdef COLLECTOR_SAT_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    return v[7:0];
  endfunction

  // Turn the model's partial element list into an expected word
  task automatic push_part();
    exp_t e;
    e.data = '0;
    for (int i = 0; i < part.size(); i++) e.data[55-8*i -: 8] = part[i];
    e.cnt = 3'(part.size());
    sb.push_back(e);
    part.delete();
  endtask

  // Drive one sample (optionally with flush) for one cycle; called at posedge+1
  task automatic send(input int v, input bit fl);
    in_data  = 16'(v);
    in_valid = 1'b1;
    flush    = fl;
    if (in_ready) begin
      part.push_back(narrow(v));
      if (part.size() == 7) push_part();
      else if (fl) push_part();
    end
    @(posedge clk); #1;
  endtask

  task automatic flush_only();
    in_valid = 1'b0;
    flush    = 1'b1;
    if (in_ready && part.size() > 0) push_part();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Consumer-side scoreboard check
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_pop: unexpected word %h count %0d", out_data, out_count);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_count !== mon_e.cnt) begin
          miscompares++;
          $display("FAIL sb_word: got %h/%0d expected %h/%0d",
                   out_data, out_count, mon_e.data, mon_e.cnt);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, out_data, out_count, overrun, sat_seen} !== {1'b1, 1'b0, 56'h0, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d ovr=%b sat=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_count, overrun, sat_seen);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: sample %0d in_ready=%b expected 1", i, in_ready);
      end
      send(i, 1'b0);
      if (i == 7 || i == 14) begin
        vectors++;
        if (out_valid !== 1'b1 || out_count !== 3'd7 ||
            out_data !== ((i == 7) ? 56'h01020304050607 : 56'h08090A0B0C0D0E)) begin
          miscompares++;
          $display("FAIL b2b_word%0d: vld=%b data=%h cnt=%0d", i / 7, out_valid, out_data, out_count);
        end
      end
    end
    idle();
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 1; i <= 14; i++) send(i, 1'b0);
    idle();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 56'h01020304050607) begin
      miscompares++;
      $display("FAIL stall_hold: rdy=%b vld=%b data=%h expected 0 1 01020304050607",
               in_ready, out_valid, out_data);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_no_overrun: overrun=%b expected 0", overrun);
    end
    send(15, 1'b0);
    idle();
    vectors++;
    if (overrun !== 1'b1 || in_ready !== 1'b0 || out_data !== 56'h01020304050607) begin
      miscompares++;
      $display("FAIL stall_overrun: ovr=%b rdy=%b data=%h expected 1 0 01020304050607",
               overrun, in_ready, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 56'h08090A0B0C0D0E || out_count !== 3'd7 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: vld=%b data=%h cnt=%0d rdy=%b expected 1 08090a0b0c0d0e 7 1",
               out_valid, out_data, out_count, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(-86, 1'b0); send(-69, 1'b0); send(-52, 1'b0);
    idle();
    flush_only();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 56'hAABBCC00000000 || out_count !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_partial: vld=%b data=%h cnt=%0d expected 1 aabbcc00000000 3",
               out_valid, out_data, out_count);
    end
    @(posedge clk); #1;
    flush_only();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: out_valid=%b expected 0", out_valid);
    end
    send(-35, 1'b1);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 56'hDD000000000000 || out_count !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_with_accept: vld=%b data=%h cnt=%0d expected 1 dd000000000000 1",
               out_valid, out_data, out_count);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= 6; i++) send(i, 1'b0);
    send(7, 1'b1);
    idle();
    vectors++;
    if (out_data !== 56'h01020304050607 || out_count !== 3'd7) begin
      miscompares++;
      $display("FAIL flush_on_complete: data=%h cnt=%0d expected 01020304050607 7", out_data, out_count);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_on_complete_extra: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_sat();
    logic [55:0] exp_d;
    logic        exp_s;
`ifdef COLLECTOR_SAT_EN
    exp_d = 56'h7F800500000000;
    exp_s = 1'b1;
`else
    exp_d = 56'h2CD40500000000;
    exp_s = 1'b0;
`endif
    out_ready = 1'b1;
    vectors++;
    if (sat_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_before: sat_seen=%b expected 0", sat_seen);
    end
    send(300, 1'b0); send(-300, 1'b0); send(5, 1'b1);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_count !== 3'd3 || sat_seen !== exp_s) begin
      miscompares++;
      $display("FAIL sat_word: vld=%b data=%h cnt=%0d sat=%b expected 1 %h 3 %b",
               out_valid, out_data, out_count, sat_seen, exp_d, exp_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) send(32 + i, 1'b0);
    send(100, 1'b0);
    send(101, 1'b0);
    send(102, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: vld=%b ovr=%b expected 1 1", out_valid, overrun);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_data, out_count, overrun, sat_seen} !== {1'b1, 1'b0, 56'h0, 3'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset: rdy=%b vld=%b data=%h cnt=%0d ovr=%b sat=%b expected 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_count, overrun, sat_seen);
    end
    sb.delete();
    part.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(8'h11 + i, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 56'h11121314151617 || out_count !== 3'd7) begin
      miscompares++;
      $display("FAIL mid_clean: vld=%b data=%h cnt=%0d expected 1 11121314151617 7",
               out_valid, out_data, out_count);
    end
  endtask

  task automatic test_drain();
    int budget;
    budget = 50;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words never produced", sb.size());
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_back_to_back();
    test_stall();
    test_flush();
    test_sat();
    test_reset_mid();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
